// File: rtl/exec_pkg.sv
// exec_pkg: op codes, flag bit positions and FSM encoding shared by the accumulator execution unit
package exec_pkg;
  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SBB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_RCL  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_CLR  = 4'd13;
  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_V = 0;
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational result and next {C,Z,N,V} for every single-cycle accumulator op
module exec_alu import exec_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f_in,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       f_out
);
  logic             cin;
  logic             c;
  logic             v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  assign cin = f_in[F_C];
  assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(op == OP_ADC && cin);
  assign dif = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(op == OP_SBB && cin);
  // result plus carry/overflow for the selected op; no-op codes pass acc through
  always_comb begin
    res = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_LOAD: begin
        res = b;
        c = f_in[F_C];
        v = f_in[F_V];
      end
      OP_ADD, OP_ADC: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        res = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      OP_RCL: begin
        res = {a[WIDTH-2:0], cin};
        c = a[WIDTH-1];
      end
      OP_CLR: res = '0;
      default: res = a;
    endcase
  end
  assign f_out = op == OP_CLR ? 4'b0000 : op >= OP_MUL ? f_in : {c, res == '0, res[WIDTH-1], v};
endmodule

// File: rtl/exec_unit.sv
// exec_unit: accumulator datapath with single-cycle ALU ops and a WIDTH-cycle shift-add multiply
module exec_unit import exec_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] ph;
  logic [WIDTH-1:0] pl;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   psum;
  logic [3:0]       alu_f;
  logic [3:0]       mul_f;
  logic             go;
  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .a(acc),
    .b(in_b),
    .f_in(flags),
    .op(op),
    .res(alu_r),
    .f_out(alu_f)
  );
  assign go = state == S_IDLE && start;
  assign busy = state == S_MUL;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  // enter MUL on a multiply request, leave after the step taken at count zero
  always_comb state_d = go && op == OP_MUL ? S_MUL : state == S_MUL && cnt != '0 ? S_MUL : S_IDLE;
  // one shift-add step: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right
  always_comb begin
    psum = {1'b0, ph} + (pl[0] ? {1'b0, mcand} : '0);
    step_hi = psum[WIDTH:1];
    step_lo = {psum[0], pl[WIDTH-1:1]};
    mul_f = {step_hi != '0, {step_hi, step_lo} == '0, step_lo[WIDTH-1], step_hi != '0};
  end
  // architectural registers, multiply sequencer and done pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      hi <= '0;
      flags <= '0;
      done <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      ph <= '0;
      pl <= '0;
    end else begin
      done <= 1'b0;
      if (go && op == OP_MUL) begin
        mcand <= acc;
        ph <= '0;
        pl <= in_b;
        cnt <= CNT_INIT;
      end else if (go) begin
        acc <= alu_r;
        flags <= alu_f;
        if (op == OP_CLR) hi <= '0;
        done <= 1'b1;
      end else if (state == S_MUL) begin
        ph <= step_hi;
        pl <= step_lo;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          acc <= step_lo;
          hi <= step_hi;
          flags <= mul_f;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed checks on an 8-bit unit plus a random regression on a 16-bit unit
module tb_exec_unit;
  import exec_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [7:0]  in_b = 8'd0;
  logic [7:0]  acc;
  logic [7:0]  hi;
  logic [3:0]  flags;
  logic        busy;
  logic        done;
  logic        start16 = 1'b0;
  logic [3:0]  op16 = 4'd0;
  logic [15:0] b16 = 16'd0;
  logic [15:0] acc16;
  logic [15:0] hi16;
  logic [3:0]  flags16;
  logic        busy16;
  logic        done16;
  logic [15:0] macc;
  logic [15:0] mhi;
  logic [3:0]  mf;
  int checks = 0;
  int failures = 0;

  exec_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_b(in_b),
    .acc(acc), .hi(hi), .flags(flags), .busy(busy), .done(done)
  );
  exec_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .in_b(b16),
    .acc(acc16), .hi(hi16), .flags(flags16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] b);
    start = 1'b1;
    op = o;
    in_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect8(input string tag, input logic [7:0] a, input logic [3:0] f);
    chk({tag, " acc"}, acc, a);
    chk({tag, " flags"}, flags, f);
    chk({tag, " done"}, done, 1);
  endtask

  task automatic wait_done8(input string tag);
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, done, 1);
  endtask

  function automatic void model16(input logic [3:0] o, input logic [15:0] b);
    int ua, ub, ci, s;
    longint p;
    logic [15:0] r;
    logic c, v;
    ua = int'(macc);
    ub = int'(b);
    ci = int'(mf[3]);
    r = macc;
    c = 1'b0;
    v = 1'b0;
    case (o)
      4'd0: begin r = b; c = mf[3]; v = mf[0]; end
      4'd1, 4'd2: begin
        s = ua + ub + (o == 4'd2 ? ci : 0);
        r = s[15:0];
        c = s > 65535;
        s = int'($signed(macc)) + int'($signed(b)) + (o == 4'd2 ? ci : 0);
        v = s > 32767 || s < -32768;
      end
      4'd3, 4'd4: begin
        s = ua - ub - (o == 4'd4 ? ci : 0);
        r = s[15:0];
        c = s < 0;
        s = int'($signed(macc)) - int'($signed(b)) - (o == 4'd4 ? ci : 0);
        v = s > 32767 || s < -32768;
      end
      4'd5: r = macc & b;
      4'd6: r = macc | b;
      4'd7: r = macc ^ b;
      4'd8: r = ~macc;
      4'd9: begin r = macc << 1; c = macc[15]; end
      4'd10: begin r = macc >> 1; c = macc[0]; end
      4'd11: begin r = (macc << 1) | 16'(ci); c = macc[15]; end
      4'd12: begin
        p = longint'(ua) * longint'(ub);
        mhi = p[31:16];
        macc = p[15:0];
        mf = {mhi != 16'd0, p == 0, macc[15], mhi != 16'd0};
        return;
      end
      4'd13: begin macc = '0; mhi = '0; mf = '0; return; end
      default: return;
    endcase
    macc = r;
    mf = {c, r == 16'd0, r[15], v};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {hi, acc, flags, busy, done}, 0);
    @(negedge clk) rst_n = 1'b1;
    issue(OP_LOAD, 8'hF0); expect8("load_f0", 8'hF0, 4'b0010);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    issue(OP_ADD, 8'h20); expect8("add_20", 8'h10, 4'b1000);
    issue(OP_LOAD, 8'h00); expect8("load_keeps_c", 8'h00, 4'b1100);
    issue(OP_CLR, 8'h00); expect8("clr", 8'h00, 4'b0000);
    issue(OP_LOAD, 8'hFF); expect8("load_ff", 8'hFF, 4'b0010);
    issue(OP_ADD, 8'h01); expect8("add_wrap", 8'h00, 4'b1100);
    issue(OP_ADC, 8'h00); expect8("adc", 8'h01, 4'b0000);
    issue(OP_SBB, 8'h02); expect8("sbb_borrow", 8'hFF, 4'b1010);
    issue(OP_SBB, 8'h00); expect8("sbb_cin", 8'hFE, 4'b0010);
    issue(OP_LOAD, 8'h7F); expect8("load_7f", 8'h7F, 4'b0000);
    issue(OP_ADD, 8'h01); expect8("add_ovf", 8'h80, 4'b0011);
    issue(OP_SUB, 8'h01); expect8("sub_ovf", 8'h7F, 4'b0001);
    issue(OP_AND, 8'h0F); expect8("and", 8'h0F, 4'b0000);
    issue(OP_OR, 8'hF0); expect8("or", 8'hFF, 4'b0010);
    issue(OP_XOR, 8'hFF); expect8("xor", 8'h00, 4'b0100);
    issue(OP_NOT, 8'h00); expect8("not", 8'hFF, 4'b0010);
    issue(OP_SHR, 8'h00); expect8("shr", 8'h7F, 4'b1000);
    issue(OP_LOAD, 8'hC8); expect8("load_c8", 8'hC8, 4'b1010);
    issue(OP_MUL, 8'h0A);
    chk("mul_cycle0", {busy, done}, 2'b10);
    for (int i = 1; i < 8; i++) begin
      start = i[0];
      op = OP_CLR;
      in_b = 8'(i * 37);
      @(posedge clk);
      #1;
      chk($sformatf("mul_cycle%0d", i), {busy, done}, 2'b10);
    end
    start = 1'b1;
    op = OP_LOAD;
    in_b = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mul_end_handshake", {busy, done}, 2'b01);
    chk("mul_acc", acc, 8'hD0);
    chk("mul_hi", hi, 8'h07);
    chk("mul_flags", flags, 4'b1011);
    @(posedge clk);
    #1;
    chk("mul_late_start_ignored", {acc, done}, {8'hD0, 1'b0});
    issue(OP_LOAD, 8'h03);
    issue(OP_MUL, 8'h05);
    repeat (3) @(posedge clk);
    #1;
    chk("mul2_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mul", {hi, acc, flags, busy, done}, 0);
    @(negedge clk) rst_n = 1'b1;
    issue(OP_ADD, 8'h05); expect8("add_after_reset", 8'h05, 4'b0000);
    chk("hi_after_reset", hi, 0);
    issue(OP_LOAD, 8'h81); expect8("load_81", 8'h81, 4'b0010);
    issue(OP_SHL, 8'h00); expect8("shl", 8'h02, 4'b1000);
    issue(4'd15, 8'hAA); expect8("nop15", 8'h02, 4'b1000);
    issue(OP_RCL, 8'h00); expect8("rcl", 8'h05, 4'b0000);
    issue(OP_LOAD, 8'hFF);
    issue(OP_MUL, 8'hFF);
    wait_done8("mul_ff_done");
    chk("mul_ff_result", {hi, acc, flags}, {8'hFE, 8'h01, 4'b1001});
    issue(4'd14, 8'h33); expect8("nop14", 8'h01, 4'b1001);
    chk("nop14_hi", hi, 8'hFE);
    issue(OP_CLR, 8'h00); expect8("clr_all", 8'h00, 4'b0000);
    chk("clr_hi", hi, 0);
    macc = '0;
    mhi = '0;
    mf = '0;
    for (int t = 0; t < 150; t++) begin
      logic [3:0] o;
      logic [15:0] b;
      o = 4'($urandom_range(0, 15));
      b = 16'($urandom);
      if (t % 10 == 0) b = (t % 20 == 0) ? 16'h0000 : 16'hFFFF;
      if (t % 7 == 3) b = 16'h7FFF;
      model16(o, b);
      start16 = 1'b1;
      op16 = o;
      b16 = b;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      for (int n = 0; n < 40 && !done16; n++) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("w16_step%0d_op%0d", t, o), {hi16, acc16, flags16, done16}, {mhi, macc, mf, 1'b1});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
